// File: rtl/miner_pkg.sv
// Shared definitions for the miner work-loading front end:
// loader state encoding, frame constants and SHA-256 block-2 padding.
package miner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
    localparam int         HEADER_BYTES      = 80;
    localparam int         HEADER_BITS       = HEADER_BYTES * 8;
    localparam logic [6:0] LAST_INDEX        = 7'(HEADER_BYTES - 1);

    // 0x80 terminator, zero fill, then the 640-bit message length.
    localparam logic [383:0] BLK2_PAD = {
        8'h80, 312'b0, 64'h0000_0000_0000_0280
    };

endpackage

// File: rtl/work_timeout_timer.sv
// Inter-byte idle timer for the work loader.
// Ports: clock, reset; enable (count while high), clear (restart count),
//        expire (one-cycle pulse on the TIMEOUT_CYCLES-th idle clock).
module work_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int             W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0]   LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear || !enable) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Fires on the clock that would complete TIMEOUT_CYCLES idle clocks.
    assign expire = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/work_loader.sv
// Assembles an 80-byte block header from a UART byte stream into the two
// SHA-256 input blocks and holds it for the miner.
// Ports: clock, reset (sync, active high); rx_valid/rx_data byte strobe;
//        work_valid/work_ready handoff; blk1/blk2 blocks; frame_err pulse;
//        drop_count (bytes discarded while work is held, saturating).
// Build option: WORK_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module work_loader
    import miner_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         work_valid,
    input  logic         work_ready,
    output logic [511:0] blk1,
    output logic [511:0] blk2,
    output logic         frame_err,
    output logic [7:0]   drop_count
);

    state_t state, state_next;

    logic [HEADER_BITS-1:0] hdr;
    logic [6:0]             idx;

    logic start;
    logic load_byte;
    logic drop;
    logic err_next;
    logic timer_en;
    logic expire;

`ifdef WORK_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    work_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (timer_en),
        .clear  (rx_valid),
        .expire (expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        load_byte  = 1'b0;
        drop       = 1'b0;
        err_next   = 1'b0;
        timer_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_next = LOAD;
                    start      = 1'b1;
                end
            end
            LOAD: begin
                timer_en = 1'b1;
                if (rx_valid) begin
                    load_byte = 1'b1;
                    if (idx == LAST_INDEX) begin
`ifdef WORK_LOADER_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = HOLD;
`endif
                    end
                end else if (expire) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
`ifdef WORK_LOADER_CHECKSUM_EN
            CHECK: begin
                timer_en = 1'b1;
                if (rx_valid) begin
                    if (rx_data == csum) begin
                        state_next = HOLD;
                    end else begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end else if (expire) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
`endif
            HOLD: begin
                // Every byte here is discarded, even a sync byte that
                // arrives on the handoff cycle.
                drop = rx_valid;
                if (work_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hdr        <= '0;
            idx        <= '0;
            frame_err  <= 1'b0;
            drop_count <= '0;
`ifdef WORK_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            frame_err <= err_next;
            if (start) begin
                idx <= '0;
`ifdef WORK_LOADER_CHECKSUM_EN
                csum <= '0;
`endif
            end
            if (load_byte) begin
                // Shift in at the bottom: after 80 bytes byte 0 sits at
                // the top, giving the MSB-first block layout.
                hdr <= {hdr[HEADER_BITS-9:0], rx_data};
                idx <= idx + 1'b1;
`ifdef WORK_LOADER_CHECKSUM_EN
                csum <= csum ^ rx_data;
`endif
            end
            if (drop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign work_valid = (state == HOLD);
    assign blk1       = hdr[HEADER_BITS-1:128];
    assign blk2       = {hdr[127:0], BLK2_PAD};

endmodule

// File: tb/tb_work_loader.sv
// Self-checking bench for work_loader: table vectors, randomized frames
// against a header-array model, and multi-cycle corner sequences.
module tb_work_loader;

    localparam int TO = 16;

`ifdef WORK_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         work_valid;
    logic         work_ready;
    logic [511:0] blk1;
    logic [511:0] blk2;
    logic         frame_err;
    logic [7:0]   drop_count;

    work_loader #(
        .SYNC_BYTE(8'h55),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .work_valid (work_valid),
        .work_ready (work_ready),
        .blk1       (blk1),
        .blk2       (blk2),
        .frame_err  (frame_err),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int err_pulses = 0;
    int exp_drop = 0;

    logic [7:0] hdr [80];

    always @(negedge clock) begin
        if (frame_err === 1'b1) err_pulses++;
    end

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        bit         bad;
        bit         exp_valid;
        int         exp_err;
        logic [7:0] exp_b0;
        logic [7:0] exp_b64;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] a,
                       input logic [511:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 80; i++) r ^= hdr[i];
        return r;
    endfunction

    function automatic logic [511:0] exp_blk1();
        logic [511:0] r = '0;
        for (int i = 0; i < 64; i++) r[511-8*i -: 8] = hdr[i];
        return r;
    endfunction

    function automatic logic [511:0] exp_blk2();
        logic [511:0] r = '0;
        for (int j = 0; j < 16; j++) r[511-8*j -: 8] = hdr[64+j];
        r[383:0] = {8'h80, 312'b0, 64'h0000000000000280};
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic fill_lin(input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < 80; i++)
            hdr[i] = 8'(int'(base) + int'(step) * i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 80; i++) hdr[i] = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input int maxgap, input bit bad,
                              input int long_at);
        send(8'h55, 0);
        for (int i = 0; i < 80; i++)
            send(hdr[i], (i == long_at) ? TO - 1 : $urandom_range(0, maxgap));
        if (CK) send(bad ? (xsum() ^ 8'h01) : xsum(),
                     $urandom_range(0, maxgap));
    endtask

    task automatic check_blocks(input string nm);
        chk({nm, " blk1"}, blk1, exp_blk1());
        chk({nm, " blk2"}, blk2, exp_blk2());
    endtask

    task automatic accept(input bit with_byte);
        work_ready = 1'b1;
        if (with_byte) begin
            rx_valid = 1'b1;
            rx_data  = 8'h55;
        end
        tick();
        work_ready = 1'b0;
        rx_valid   = 1'b0;
        if (with_byte) exp_drop = sat(exp_drop + 1);
        chk("accept clears work_valid", work_valid, 0);
        chk("drop_count after accept", drop_count, exp_drop);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int first;
        bit bad;
        int k;

        vecs[0] = '{8'h00, 8'h01, 1'b0, 1'b1, 0, 8'h00, 8'h40};
        vecs[1] = '{8'h00, 8'h01, 1'b1, !CK, CK ? 1 : 0, 8'h00, 8'h40};
        vecs[2] = '{8'h55, 8'h00, 1'b0, 1'b1, 0, 8'h55, 8'h55};
        vecs[3] = '{8'hFF, 8'h03, 1'b0, 1'b1, 0, 8'hFF, 8'hBF};
        vecs[4] = '{8'h10, 8'h07, 1'b1, !CK, CK ? 1 : 0, 8'h10, 8'hD0};

        reset      = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        work_ready = 1'b0;
        tick();
        tick();
        chk("reset work_valid", work_valid, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset drop_count", drop_count, 0);
        chk("reset blk1", blk1, 512'b0);
        chk("reset blk2", blk2,
            {128'b0, 8'h80, 312'b0, 64'h0000000000000280});
        reset = 1'b0;
        tick();

        // Table vectors
        for (int v = 0; v < 5; v++) begin
            fill_lin(vecs[v].base, vecs[v].step);
            e0 = err_pulses;
            send_frame(3, vecs[v].bad, -1);
            chk($sformatf("vec%0d work_valid", v), work_valid,
                vecs[v].exp_valid);
            if (vecs[v].exp_valid) begin
                chk($sformatf("vec%0d blk1 byte0", v), blk1[511:504],
                    vecs[v].exp_b0);
                chk($sformatf("vec%0d blk2 byte64", v), blk2[511:504],
                    vecs[v].exp_b64);
                chk($sformatf("vec%0d blk2 length", v), blk2[63:0],
                    64'h280);
                check_blocks($sformatf("vec%0d", v));
            end
            tick();
            chk($sformatf("vec%0d frame_err pulses", v), err_pulses - e0,
                vecs[v].exp_err);
            if (vecs[v].exp_valid) accept(1'b0);
        end

        // Randomized frames against the header model
        for (int r = 0; r < 20; r++) begin
            k = $urandom_range(0, 3);
            for (int g = 0; g < k; g++) begin
                rx_data = 8'($urandom);
                if (rx_data == 8'h55) rx_data = 8'h56;
                send(rx_data, $urandom_range(0, 2));
            end
            fill_rand();
            bad = CK && ($urandom_range(0, 3) == 0);
            e0 = err_pulses;
            send_frame(4, bad, -1);
            chk($sformatf("rnd%0d work_valid", r), work_valid, !bad);
            tick();
            chk($sformatf("rnd%0d frame_err", r), err_pulses - e0,
                bad ? 1 : 0);
            if (!bad) begin
                check_blocks($sformatf("rnd%0d", r));
                k = $urandom_range(0, 3);
                for (int d = 0; d < k; d++) send(8'($urandom), 0);
                exp_drop = sat(exp_drop + k);
                chk($sformatf("rnd%0d held", r), work_valid, 1);
                check_blocks($sformatf("rnd%0d held", r));
                accept(1'($urandom_range(0, 1)));
            end
        end

        // Latency of work_valid relative to the final frame byte
        fill_lin(8'h00, 8'h01);
        send(8'h55, 0);
        for (int i = 0; i < 79; i++) send(hdr[i], 0);
        chk("latency before last byte", work_valid, 0);
        send(hdr[79], 0);
`ifdef WORK_LOADER_CHECKSUM_EN
        chk("latency awaiting checksum", work_valid, 0);
        send(xsum(), 0);
`endif
        chk("latency after final byte", work_valid, 1);
        check_blocks("latency");
        accept(1'b0);

        // Inter-byte timeout
        send(8'h55, 0);
        for (int i = 0; i < 40; i++) send(8'($urandom), 0);
        e0 = err_pulses;
        first = 0;
        for (int c = 1; c <= TO + 2; c++) begin
            tick();
            if (frame_err && first == 0) first = c;
        end
        chk("timeout cycle", first, TO);
        chk("timeout pulse count", err_pulses - e0, 1);
        chk("timeout work_valid", work_valid, 0);
        fill_rand();
        send_frame(2, 1'b0, -1);
        chk("after timeout work_valid", work_valid, 1);
        check_blocks("after timeout");
        accept(1'b0);

        // Longest legal gap must not time out
        fill_lin(8'h03, 8'h05);
        e0 = err_pulses;
        send_frame(0, 1'b0, 40);
        chk("max gap work_valid", work_valid, 1);
        check_blocks("max gap");
        tick();
        chk("max gap no error", err_pulses - e0, 0);
        accept(1'b0);

        // Drop counter saturation while holding
        fill_rand();
        send_frame(2, 1'b0, -1);
        chk("sat work_valid", work_valid, 1);
        for (int d = 0; d < 300; d++) send(8'($urandom), 0);
        exp_drop = sat(exp_drop + 300);
        chk("sat drop_count", drop_count, 8'hFF);
        check_blocks("sat held");
        chk("sat still valid", work_valid, 1);
        accept(1'b1);

        // Reset in the middle of a frame
        fill_lin(8'h20, 8'h01);
        send(8'h55, 0);
        for (int i = 0; i < 50; i++) send(hdr[i], 0);
        e0 = err_pulses;
        reset = 1'b1;
        tick();
        chk("midreset work_valid", work_valid, 0);
        chk("midreset frame_err", frame_err, 0);
        chk("midreset drop_count", drop_count, 0);
        chk("midreset blk1", blk1, 512'b0);
        chk("midreset blk2 data", blk2[511:384], 128'b0);
        reset = 1'b0;
        exp_drop = 0;
        tick();
        tick();
        chk("midreset no error", err_pulses - e0, 0);
        fill_lin(8'hA0, 8'h01);
        send_frame(3, 1'b0, -1);
        chk("post reset work_valid", work_valid, 1);
        check_blocks("post reset");
        accept(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
